// File: rtl/jtag_host_ctrl.sv
// jtag_host_ctrl: JTAG TAP driver that runs one scan command at a time.
// It generates TCK/TMS/TDI from clk and returns the captured TDO over valid/ready.
module jtag_host_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 64,
   localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_tdi,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_tdo,
   output logic               jtag_trstn,
   output logic               jtag_tck,
   output logic               jtag_tms,
   output logic               jtag_tdi,
   input  logic               jtag_tdo
);
   localparam int IW = LEN_W > 3 ? LEN_W : 3;
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] C_RISE = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_LAST = CW'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RUN, RSP} state_t;

   state_t state, state_n, cur_nxt, emit_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n, len, len_n, len_c, cur_cnt, emit_i;
   logic [1:0] op, op_n;
   logic [MAX_LEN-1:0] tdi_sh, tdi_sh_n, rsp_tdo_n;
   logic cmd_ready_n, rsp_valid_n, tck_n, tms_n, tdi_n, emit_tms;

   assign len_c = cmd_len > LEN_W'(MAX_LEN) ? IW'(MAX_LEN) : IW'(cmd_len);

   // At each pulse boundary either the current phase emits its next pulse, or
   // it hands over to its successor, which emits its first pulse on the same edge.
   always_comb begin
      cur_cnt = state == INIT ? IW'(6) : state == PRE ? (op[0] ? IW'(4) : IW'(3)) :
                state == POST ? IW'(2) : (state == SHIFT || state == RUN) ? len : '0;
      cur_nxt = state == PRE ? SHIFT : state == SHIFT ? POST :
                (state == INIT && op != 2'd2) ? IDLE : RSP;
      emit_s = idx < cur_cnt ? state : cur_nxt;
      emit_i = idx < cur_cnt ? idx : '0;
      emit_tms = emit_s == INIT ? emit_i < IW'(5) :
                 emit_s == PRE ? (op[0] ? emit_i < IW'(2) : emit_i == '0) :
                 emit_s == SHIFT ? emit_i == len - 1'b1 :
                 emit_s == POST ? emit_i == '0 : 1'b0;
      state_n = state;
      cnt_n = cnt == C_LAST ? '0 : cnt + 1'b1;
      idx_n = idx;
      len_n = len;
      op_n = op;
      tdi_sh_n = tdi_sh;
      rsp_tdo_n = rsp_tdo;
      cmd_ready_n = cmd_ready;
      rsp_valid_n = rsp_valid;
      tck_n = jtag_tck;
      tms_n = jtag_tms;
      tdi_n = jtag_tdi;
      if (state == IDLE) begin
         if (cmd_valid) begin
            state_n = cmd_op == 2'd2 ? INIT : (cmd_op == 2'd3 || len_c == '0) ? RUN : PRE;
            cnt_n = C_LAST;
            idx_n = '0;
            len_n = len_c;
            op_n = cmd_op;
            tdi_sh_n = cmd_tdi;
            rsp_tdo_n = '0;
            cmd_ready_n = 1'b0;
         end
      end else if (state == RSP) begin
         if (rsp_ready) begin
            state_n = IDLE;
            rsp_valid_n = 1'b0;
            cmd_ready_n = 1'b1;
         end
      end else if (cnt == C_RISE) begin
         tck_n = 1'b1;
         if (state == SHIFT) rsp_tdo_n = rsp_tdo | (MAX_LEN'(jtag_tdo) << (idx - 1'b1));
      end else if (cnt == C_LAST) begin
         tck_n = 1'b0;
         state_n = emit_s;
         idx_n = emit_i + 1'b1;
         tms_n = emit_tms;
         tdi_n = emit_s == SHIFT && tdi_sh[0];
         if (emit_s == SHIFT) tdi_sh_n = tdi_sh >> 1;
         if (emit_s == RSP) rsp_valid_n = 1'b1;
         if (emit_s == IDLE) cmd_ready_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt <= C_LAST;
         idx <= '0;
         len <= '0;
         op <= '0;
         tdi_sh <= '0;
         rsp_tdo <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         jtag_trstn <= 1'b0;
         jtag_tck <= 1'b0;
         jtag_tms <= 1'b1;
         jtag_tdi <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         len <= len_n;
         op <= op_n;
         tdi_sh <= tdi_sh_n;
         rsp_tdo <= rsp_tdo_n;
         cmd_ready <= cmd_ready_n;
         rsp_valid <= rsp_valid_n;
         jtag_trstn <= 1'b1;
         jtag_tck <= tck_n;
         jtag_tms <= tms_n;
         jtag_tdi <= tdi_n;
      end
   end
endmodule
